// File: rtl/twoway_cache_param.sv
// twoway_cache_param: two-way set-associative write-through cache for TG68/SDRAM; define CACHE_FLUSH_EN to add a flush input
module twoway_cache_param #(
  parameter int ADDR_W     = 26,
  parameter int SET_BITS   = 6,
  parameter int BURST_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic        cpu_wru,
  input  logic        cpu_wrl,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        cpu_ack,
  output logic [31:0] sdram_addr,
  output logic        sdram_req,
  output logic        sdram_rw,
  output logic [1:0]  sdram_bytesel,
  output logic [15:0] data_to_sdram,
  input  logic [15:0] data_from_sdram,
  input  logic        sdram_fill,
  input  logic        sdram_ack,
`ifdef CACHE_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy
);
  localparam int OFS   = BURST_LOG2 + 1;
  localparam int TAG_W = ADDR_W - SET_BITS - OFS;
  localparam int NS    = 1 << SET_BITS;
  localparam int NW    = 1 << (SET_BITS + BURST_LOG2);
  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, FILL, WMEM, DONE} state_t;
  state_t state;
  logic [SET_BITS-1:0] initctr;
  logic [BURST_LOG2-1:0] fill_ctr;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic rw_q, wru_q, wrl_q, victim_q;
  logic [NS-1:0] lru, val0, val1;
  logic [TAG_W-1:0] tag0 [NS];
  logic [TAG_W-1:0] tag1 [NS];
  logic [15:0] dram0 [NW];
  logic [15:0] dram1 [NW];
  logic [SET_BITS-1:0] set_q;
  logic [BURST_LOG2-1:0] word_q;
  logic [TAG_W-1:0] tag_q;
  logic [SET_BITS+BURST_LOG2-1:0] idx;
  logic hit0, hit1, victim, flush_go;
  logic [15:0] rd0, rd1, old, merged;
  assign set_q  = addr_q[OFS+SET_BITS-1:OFS];
  assign word_q = addr_q[OFS-1:1];
  assign tag_q  = addr_q[ADDR_W-1:OFS+SET_BITS];
  assign idx    = {set_q, word_q};
  assign rd0    = dram0[idx];
  assign rd1    = dram1[idx];
  assign hit0   = val0[set_q] && tag0[set_q] == tag_q;
  assign hit1   = !hit0 && val1[set_q] && tag1[set_q] == tag_q;
  assign old    = hit0 ? rd0 : rd1;
  assign merged = {wru_q ? old[15:8] : wdata_q[15:8], wrl_q ? old[7:0] : wdata_q[7:0]};
  // invalid way first, otherwise the least recently used way
  assign victim = !val0[set_q] ? 1'b0 : !val1[set_q] ? 1'b1 : !lru[set_q];
`ifdef CACHE_FLUSH_EN
  logic flush_pend;
  assign flush_go = flush | flush_pend;
  always_ff @(posedge clk or negedge reset)
    if (!reset) flush_pend <= 1'b0;
    else flush_pend <= state == IDLE ? 1'b0 : flush_pend | flush;
`else
  assign flush_go = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      initctr <= '0;
      fill_ctr <= '0;
      busy <= 1'b0;
      cpu_ack <= 1'b0;
      data_to_cpu <= '0;
      sdram_addr <= '0;
      sdram_req <= 1'b0;
      sdram_rw <= 1'b0;
      sdram_bytesel <= '0;
      data_to_sdram <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      wru_q <= 1'b1;
      wrl_q <= 1'b1;
      victim_q <= 1'b0;
      lru <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        INIT: begin
          lru[initctr] <= 1'b0;
          if (!busy) busy <= 1'b1;
          else begin
            initctr <= initctr + 1'b1;
            if (&initctr) begin
              busy <= 1'b0;
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (flush_go) begin
            busy <= 1'b1;
            initctr <= '0;
            state <= INIT;
          end else if (cpu_req) begin
            addr_q <= cpu_addr;
            wdata_q <= data_from_cpu;
            rw_q <= cpu_rw;
            wru_q <= cpu_wru;
            wrl_q <= cpu_wrl;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rw_q && (hit0 || hit1)) begin
            data_to_cpu <= hit0 ? rd0 : rd1;
            cpu_ack <= 1'b1;
            lru[set_q] <= hit1;
            state <= DONE;
          end else if (rw_q) begin
            victim_q <= victim;
            sdram_addr <= {addr_q[31:OFS], {OFS{1'b0}}};
            sdram_rw <= 1'b1;
            sdram_req <= 1'b1;
            fill_ctr <= '0;
            state <= FILL;
          end else begin
            sdram_addr <= addr_q;
            sdram_rw <= 1'b0;
            data_to_sdram <= wdata_q;
            sdram_bytesel <= {~wru_q, ~wrl_q};
            sdram_req <= 1'b1;
            if (hit0 || hit1) lru[set_q] <= hit1;
            state <= WMEM;
          end
        end
        FILL: begin
          if (sdram_fill) begin
            sdram_req <= 1'b0;
            if (fill_ctr == word_q) data_to_cpu <= data_from_sdram;
            fill_ctr <= fill_ctr + 1'b1;
            if (&fill_ctr) begin
              lru[set_q] <= victim_q;
              cpu_ack <= 1'b1;
              state <= DONE;
            end
          end
        end
        WMEM: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            cpu_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!cpu_req) state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
  // storage has no reset; INIT invalidates every set before first use
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      val0[initctr] <= 1'b0;
      val1[initctr] <= 1'b0;
    end
    if (state == FILL && sdram_fill) begin
      if (victim_q) dram1[{set_q, fill_ctr}] <= data_from_sdram;
      else dram0[{set_q, fill_ctr}] <= data_from_sdram;
      if (&fill_ctr && victim_q) begin
        tag1[set_q] <= tag_q;
        val1[set_q] <= 1'b1;
      end
      if (&fill_ctr && !victim_q) begin
        tag0[set_q] <= tag_q;
        val0[set_q] <= 1'b1;
      end
    end
    if (state == LOOKUP && !rw_q && hit0) dram0[idx] <= merged;
    if (state == LOOKUP && !rw_q && hit1) dram1[idx] <= merged;
  end
endmodule

// File: tb/tb_twoway_cache_param.sv
// tb_twoway_cache_param: directed vector bench for twoway_cache_param with a burst/ack SDRAM responder
module tb_twoway_cache_param;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic cpu_req = 1'b0, cpu_rw = 1'b1, cpu_wru = 1'b1, cpu_wrl = 1'b1;
  logic [15:0] data_from_cpu = '0, data_from_sdram = '0;
  logic sdram_fill = 1'b0, sdram_ack = 1'b0;
  logic [15:0] data_to_cpu, data_to_sdram;
  logic cpu_ack, sdram_req, sdram_rw, busy;
  logic [31:0] sdram_addr;
  logic [1:0] sdram_bytesel;
`ifdef CACHE_FLUSH_EN
  logic flush = 1'b0;
`endif
  twoway_cache_param dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_wru(cpu_wru), .cpu_wrl(cpu_wrl), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .cpu_ack(cpu_ack), .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_rw(sdram_rw),
    .sdram_bytesel(sdram_bytesel), .data_to_sdram(data_to_sdram), .data_from_sdram(data_from_sdram),
    .sdram_fill(sdram_fill), .sdram_ack(sdram_ack),
`ifdef CACHE_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, fill_idx = -1;
  logic [15:0] r_data, r_wd;
  logic [31:0] r_sa;
  logic [1:0] r_bs;
  logic r_sd, r_srw, r_got, r_busy_ack, r_req_ack;
  int r_lat, r_busy;
  typedef struct {
    bit rw; logic [31:0] a; logic [15:0] wd; bit wru; bit wrl;
    bit sd; logic [31:0] sa; logic [1:0] bs; logic [15:0] d;
  } vec_t;
  vec_t v [18];
  function automatic logic [15:0] sd_word(input logic [31:0] line, input int i);
    return 16'h00A0 + 16'(i) + line[15:0] - 16'h0100;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (sdram_req && sdram_rw) begin
      for (int i = 0; i < 4; i++) begin
        fill_idx = i;
        sdram_fill = 1'b1;
        data_from_sdram = sd_word(sdram_addr, i);
        @(negedge clk);
      end
      sdram_fill = 1'b0;
      fill_idx = -1;
    end else if (sdram_req) begin
      @(negedge clk);
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
    end
  end
  task automatic access(input bit rw, input logic [31:0] a, input logic [15:0] wd, input bit wru, input bit wrl);
    @(negedge clk);
    cpu_rw = rw; cpu_addr = a; data_from_cpu = wd; cpu_wru = wru; cpu_wrl = wrl; cpu_req = 1'b1;
    r_sd = 0; r_srw = 0; r_got = 0; r_lat = 0; r_busy = 0; r_busy_ack = 0; r_req_ack = 0;
    r_sa = '0; r_bs = '0; r_wd = '0; r_data = '0;
    while (!r_got && r_lat < 300) begin
      @(posedge clk); #1;
      r_lat++;
      if (busy) r_busy++;
      if (sdram_req && !r_sd) begin
        r_sd = 1; r_srw = sdram_rw; r_sa = sdram_addr; r_bs = sdram_bytesel; r_wd = data_to_sdram;
      end
      if (cpu_ack) begin
        r_got = 1; r_data = data_to_cpu; r_busy_ack = busy; r_req_ack = sdram_req;
      end
    end
    @(negedge clk);
    cpu_req = 1'b0;
    chk("ack_seen", r_got, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (70) @(posedge clk);
  endtask
  initial begin
    bit found, ack_any;
    int cnt;
    v[0]  = '{1, 32'h102, 0, 1, 1, 1, 32'h100, 0, 16'h00A1};
    v[1]  = '{1, 32'h106, 0, 1, 1, 0, 0, 0, 16'h00A3};
    v[2]  = '{1, 32'h000, 0, 1, 1, 1, 32'h000, 0, 16'hFFA0};
    v[3]  = '{1, 32'h200, 0, 1, 1, 1, 32'h200, 0, 16'h01A0};
    v[4]  = '{1, 32'h000, 0, 1, 1, 0, 0, 0, 16'hFFA0};
    v[5]  = '{1, 32'h400, 0, 1, 1, 1, 32'h400, 0, 16'h03A0};
    v[6]  = '{1, 32'h000, 0, 1, 1, 0, 0, 0, 16'hFFA0};
    v[7]  = '{1, 32'h402, 0, 1, 1, 0, 0, 0, 16'h03A1};
    v[8]  = '{1, 32'h202, 0, 1, 1, 1, 32'h200, 0, 16'h01A1};
    v[9]  = '{0, 32'h102, 16'h55AA, 0, 1, 1, 32'h102, 2'b10, 0};
    v[10] = '{1, 32'h102, 0, 1, 1, 0, 0, 0, 16'h55A1};
    v[11] = '{0, 32'h104, 16'h1234, 1, 1, 1, 32'h104, 2'b00, 0};
    v[12] = '{1, 32'h104, 0, 1, 1, 0, 0, 0, 16'h00A2};
    v[13] = '{0, 32'h806, 16'hBEEF, 0, 0, 1, 32'h806, 2'b11, 0};
    v[14] = '{1, 32'h806, 0, 1, 1, 1, 32'h800, 0, 16'h07A3};
    v[15] = '{0, 32'h100, 16'hCCDD, 1, 0, 1, 32'h100, 2'b01, 0};
    v[16] = '{1, 32'h100, 0, 1, 1, 0, 0, 0, 16'h00DD};
    v[17] = '{1, 32'h004, 0, 1, 1, 1, 32'h000, 0, 16'hFFA2};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_sreq", sdram_req, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    access(1, 32'h100, 0, 1, 1);
    chk("init_busy_cycles", r_busy, 64);
    chk("init_ack_busy", r_busy_ack, 0);
    chk("init_miss", r_sd, 1);
    chk("init_data", r_data, 16'h00A0);
    do_reset();
    foreach (v[i]) begin
      access(v[i].rw, v[i].a, v[i].wd, v[i].wru, v[i].wrl);
      chk($sformatf("v%0d_sdreq", i), r_sd, v[i].sd);
      if (v[i].sd) chk($sformatf("v%0d_saddr", i), r_sa, v[i].sa);
      if (v[i].sd) chk($sformatf("v%0d_srw", i), r_srw, v[i].rw);
      if (v[i].rw) chk($sformatf("v%0d_data", i), r_data, v[i].d);
      if (v[i].rw && !v[i].sd) chk($sformatf("v%0d_hit_lat", i), r_lat, 2);
      if (!v[i].rw) chk($sformatf("v%0d_bytesel", i), r_bs, v[i].bs);
      if (!v[i].rw) chk($sformatf("v%0d_wdata", i), r_wd, v[i].wd);
      if (!v[i].rw) chk($sformatf("v%0d_req_drop", i), r_req_ack, 0);
    end
    @(negedge clk);
    cpu_rw = 1'b1; cpu_addr = 32'h600; cpu_req = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #2;
      found = fill_idx == 1;
    end
    chk("abort_fill_word2", found, 1);
    reset = 1'b0;
    #1;
    chk("abort_sreq", sdram_req, 0);
    chk("abort_ack", cpu_ack, 0);
    cpu_req = 1'b0;
    ack_any = 0;
    repeat (5) begin
      @(posedge clk); #1;
      ack_any |= cpu_ack;
    end
    @(posedge clk); #2;
    reset = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (busy) cnt++;
      ack_any |= cpu_ack;
    end
    chk("abort_no_ack", ack_any, 0);
    chk("abort_init_rerun", cnt, 64);
    access(1, 32'h100, 0, 1, 1);
    chk("abort_line_miss", r_sd, 1);
    chk("abort_line_addr", r_sa, 32'h100);
    chk("abort_line_data", r_data, 16'h00A0);
`ifdef CACHE_FLUSH_EN
    @(negedge clk);
    flush = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (busy) cnt++;
    end
    chk("flush_busy_cycles", cnt, 64);
    access(1, 32'h102, 0, 1, 1);
    chk("flush_miss", r_sd, 1);
    chk("flush_data", r_data, 16'h00A1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
